// File: rtl/fast_corner_scheduler.sv
// fast_corner_scheduler
// Runs the FAST-9 corner test over the Gaussian-filtered image once convolution finishes.
// Pixels are visited in raster order. Border pixels are written as 0 without any reads.
// For an interior pixel the block reads the centre and the 16-pixel Bresenham ring,
// evaluates the circular contiguous-arc test and writes one result bit.
//
// Ports:
//   clk, n_rst        clock; synchronous active-high reset
//   start             one-cycle frame start pulse (ignored while not idle)
//   max_x, max_y      last valid x / y index, latched on accepted start
//   threshold         intensity threshold t, latched on accepted start
//   *_conv_fast       conv buffer read port (data valid the cycle after ren)
//   *_fast            FAST result map write port
//   busy, done        frame in progress / one-cycle end-of-frame pulse
module fast_corner_scheduler #(
   parameter int unsigned X_MAX       = 400,
   parameter int unsigned Y_MAX       = 400,
   parameter int unsigned PIXEL_DEPTH = 8,
   parameter int unsigned ARC_LEN     = 9
) (
   input  logic                     clk,
   input  logic                     n_rst,
   input  logic                     start,
   input  logic [$clog2(X_MAX)-1:0] max_x,
   input  logic [$clog2(Y_MAX)-1:0] max_y,
   input  logic [PIXEL_DEPTH-1:0]   threshold,
   output logic [$clog2(X_MAX):0]   x_addr_conv_fast,
   output logic [$clog2(Y_MAX):0]   y_addr_conv_fast,
   output logic                     ren_conv_fast,
   input  logic [PIXEL_DEPTH-1:0]   rdat_conv_fast,
   output logic [$clog2(X_MAX):0]   x_addr_fast,
   output logic [$clog2(Y_MAX):0]   y_addr_fast,
   output logic                     wen_fast,
   output logic                     wdat_fast,
   output logic                     busy,
   output logic                     done
);

   localparam int unsigned XW = $clog2(X_MAX);
   localparam int unsigned YW = $clog2(Y_MAX);
   localparam int unsigned PD = PIXEL_DEPTH;

   typedef enum logic [2:0] {StIdle, StRead, StCapture, StEval, StWrite, StDone} state_e;

   state_e          state_q, state_d;
   logic [4:0]      k_q, k_d;
   logic [XW-1:0]   x_q, x_d, max_x_q, max_x_d;
   logic [YW-1:0]   y_q, y_d, max_y_q, max_y_d;
   logic [PD-1:0]   thr_q, thr_d;
   logic [PD-1:0]   centre_q;
   logic [PD-1:0]   ring_q [16];
   logic            cap_valid_q;
   logic [4:0]      cap_idx_q;

   logic [XW:0]     cx_addr_q, cx_addr_d, wx_addr_q, wx_addr_d;
   logic [YW:0]     cy_addr_q, cy_addr_d, wy_addr_q, wy_addr_d;
   logic            ren_q, ren_d, wen_q, wen_d, wdat_q, wdat_d, busy_q, busy_d, done_q, done_d;

   logic            enter_sel;
   logic            corner;
   logic [15:0]     bright, dark;
   logic [PD:0]     c_plus_t;
   logic [5:0]      off;

   // Border test in signed arithmetic so that a max below 6 makes every pixel border.
   function automatic logic is_border(logic [XW-1:0] px, logic [YW-1:0] py,
                                      logic [XW-1:0] mx, logic [YW-1:0] my);
      int sx, sy, smx, smy;
      sx  = int'(px);
      sy  = int'(py);
      smx = int'(mx);
      smy = int'(my);
      return (sx < 3) || (sx > smx - 3) || (sy < 3) || (sy > smy - 3);
   endfunction

   // Ring offset for read index k as {dx[2:0], dy[2:0]} in two's complement; +y is down.
   function automatic logic [5:0] ring_offset(logic [4:0] k);
      logic [5:0] o;
      o = 6'b000_000;
      case (k)
         5'd1:    o = {3'b000, 3'b101};
         5'd2:    o = {3'b001, 3'b101};
         5'd3:    o = {3'b010, 3'b110};
         5'd4:    o = {3'b011, 3'b111};
         5'd5:    o = {3'b011, 3'b000};
         5'd6:    o = {3'b011, 3'b001};
         5'd7:    o = {3'b010, 3'b010};
         5'd8:    o = {3'b001, 3'b011};
         5'd9:    o = {3'b000, 3'b011};
         5'd10:   o = {3'b111, 3'b011};
         5'd11:   o = {3'b110, 3'b010};
         5'd12:   o = {3'b101, 3'b001};
         5'd13:   o = {3'b101, 3'b000};
         5'd14:   o = {3'b101, 3'b111};
         5'd15:   o = {3'b110, 3'b110};
         5'd16:   o = {3'b111, 3'b101};
         default: o = 6'b000_000;
      endcase
      return o;
   endfunction

   // True when ARC_LEN consecutive bits are set, with bit 15 adjacent to bit 0.
   function automatic logic has_arc(logic [15:0] b);
      logic       found;
      logic       run;
      logic [3:0] idx;
      found = 1'b0;
      for (int s = 0; s < 16; s++) begin
         run = 1'b1;
         for (int j = 0; j < int'(ARC_LEN); j++) begin
            idx = 4'((s + j) % 16);
            run = run & b[idx];
         end
         found = found | run;
      end
      return found;
   endfunction

   // Unsigned PD+1-bit compares so c+t and p+t never wrap.
   always_comb begin
      c_plus_t = {1'b0, centre_q} + {1'b0, thr_q};
      bright   = '0;
      dark     = '0;
      for (int i = 0; i < 16; i++) begin
         bright[i] = {1'b0, ring_q[i]} > c_plus_t;
         dark[i]   = ({1'b0, ring_q[i]} + {1'b0, thr_q}) < {1'b0, centre_q};
      end
      corner = has_arc(bright) | has_arc(dark);
   end

   // Next state; SELECT is folded in as enter_sel and resolved in the same cycle.
   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      x_d       = x_q;
      y_d       = y_q;
      max_x_d   = max_x_q;
      max_y_d   = max_y_q;
      thr_d     = thr_q;
      wdat_d    = 1'b0;
      enter_sel = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               max_x_d   = max_x;
               max_y_d   = max_y;
               thr_d     = threshold;
               x_d       = '0;
               y_d       = '0;
               enter_sel = 1'b1;
            end
         end
         StRead: begin
            if (k_q == 5'd16) state_d = StCapture;
            else              k_d     = k_q + 5'd1;
         end
         StCapture: state_d = StEval;
         StEval: begin
            state_d = StWrite;
            wdat_d  = corner;
         end
         StWrite: begin
            if (x_q == max_x_q) begin
               if (y_q == max_y_q) begin
                  state_d = StDone;
               end else begin
                  x_d       = '0;
                  y_d       = y_q + YW'(1);
                  enter_sel = 1'b1;
               end
            end else begin
               x_d       = x_q + XW'(1);
               enter_sel = 1'b1;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
      if (enter_sel) begin
         k_d     = '0;
         state_d = is_border(x_d, y_d, max_x_d, max_y_d) ? StWrite : StRead;
      end
   end

   // Registered outputs are derived from the next state.
   always_comb begin
      ren_d     = (state_d == StRead);
      wen_d     = (state_d == StWrite);
      busy_d    = (state_d != StIdle) && (state_d != StDone);
      done_d    = (state_d == StDone);
      off       = ring_offset(k_d);
      cx_addr_d = '0;
      cy_addr_d = '0;
      wx_addr_d = '0;
      wy_addr_d = '0;
      if (ren_d) begin
         cx_addr_d = {1'b0, x_d} + {{(XW - 2){off[5]}}, off[5:3]};
         cy_addr_d = {1'b0, y_d} + {{(YW - 2){off[2]}}, off[2:0]};
      end
      if (wen_d) begin
         wx_addr_d = {1'b0, x_d};
         wy_addr_d = {1'b0, y_d};
      end
   end

   always_ff @(posedge clk) begin
      if (n_rst) begin
         state_q     <= StIdle;
         k_q         <= '0;
         x_q         <= '0;
         y_q         <= '0;
         max_x_q     <= '0;
         max_y_q     <= '0;
         thr_q       <= '0;
         centre_q    <= '0;
         for (int i = 0; i < 16; i++) ring_q[i] <= '0;
         cap_valid_q <= 1'b0;
         cap_idx_q   <= '0;
         cx_addr_q   <= '0;
         cy_addr_q   <= '0;
         wx_addr_q   <= '0;
         wy_addr_q   <= '0;
         ren_q       <= 1'b0;
         wen_q       <= 1'b0;
         wdat_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         x_q         <= x_d;
         y_q         <= y_d;
         max_x_q     <= max_x_d;
         max_y_q     <= max_y_d;
         thr_q       <= thr_d;
         // Read data for index k arrives the cycle after READ k.
         cap_valid_q <= (state_q == StRead);
         cap_idx_q   <= k_q;
         if (cap_valid_q) begin
            if (cap_idx_q == 5'd0) centre_q <= rdat_conv_fast;
            else                   ring_q[4'(cap_idx_q - 5'd1)] <= rdat_conv_fast;
         end
         cx_addr_q   <= cx_addr_d;
         cy_addr_q   <= cy_addr_d;
         wx_addr_q   <= wx_addr_d;
         wy_addr_q   <= wy_addr_d;
         ren_q       <= ren_d;
         wen_q       <= wen_d;
         wdat_q      <= wdat_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign x_addr_conv_fast = cx_addr_q;
   assign y_addr_conv_fast = cy_addr_q;
   assign ren_conv_fast    = ren_q;
   assign x_addr_fast      = wx_addr_q;
   assign y_addr_fast      = wy_addr_q;
   assign wen_fast         = wen_q;
   assign wdat_fast        = wdat_q;
   assign busy             = busy_q;
   assign done             = done_q;

endmodule

// File: tb/tb_fast_corner_scheduler.sv
// Self-checking bench for fast_corner_scheduler: a conv-memory responder, a bus monitor and
// a frame-level reference model that lists expected reads/writes and the frame length.
module tb_fast_corner_scheduler;

   logic       clk = 1'b0;
   logic       n_rst, start;
   logic [8:0] max_x, max_y;
   logic [7:0] threshold, rdat;
   logic [9:0] xa_c, ya_c, xa_f, ya_f;
   logic       ren, wen, wdat, busy, done;

   fast_corner_scheduler dut (
      .clk              (clk),
      .n_rst            (n_rst),
      .start            (start),
      .max_x            (max_x),
      .max_y            (max_y),
      .threshold        (threshold),
      .x_addr_conv_fast (xa_c),
      .y_addr_conv_fast (ya_c),
      .ren_conv_fast    (ren),
      .rdat_conv_fast   (rdat),
      .x_addr_fast      (xa_f),
      .y_addr_fast      (ya_f),
      .wen_fast         (wen),
      .wdat_fast        (wdat),
      .busy             (busy),
      .done             (done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc++;

   logic [7:0] img [0:15][0:15];
   int rdx [16] = '{0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};
   int rdy [16] = '{-3, -3, -2, -1, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3};

   int rd_q[$], wr_q[$], exp_rd[$], exp_wr[$];
   int overlap = 0, done_busy = 0, bad_addr = 0;
   int start_cyc = 0, done_cyc = 0, first_act = -1, busy_c1 = -1;
   int n_int, n_bord;
   logic       pend_ren = 1'b0;
   logic [7:0] pend_val = 8'd0;

   // Monitor and conv-memory request capture, away from the active edge.
   always @(negedge clk) begin
      pend_ren = ren;
      pend_val = 8'd0;
      if (ren === 1'b1) begin
         if (xa_c < 10'd16 && ya_c < 10'd16) pend_val = img[ya_c[3:0]][xa_c[3:0]];
         else bad_addr++;
         rd_q.push_back(int'(ya_c) * 1024 + int'(xa_c));
      end
      if (wen === 1'b1) wr_q.push_back(int'(ya_f) * 2048 + int'(xa_f) * 2 + int'(wdat));
      if (ren === 1'b1 && wen === 1'b1) overlap++;
      if (done === 1'b1 && busy !== 1'b0) done_busy++;
      if ((ren === 1'b1 || wen === 1'b1) && first_act < 0) first_act = cyc - start_cyc;
      if (cyc == start_cyc + 1) busy_c1 = (busy === 1'b1) ? 1 : 0;
   end

   // Read data becomes valid in the cycle after the request.
   always @(posedge clk) begin
      #1;
      if (pend_ren) rdat = pend_val;
   end

   function automatic int longest_run(logic [15:0] b);
      int run = 0;
      int best = 0;
      for (int i = 0; i < 32; i++) begin
         if (b[i % 16]) run++;
         else run = 0;
         if (run > best) best = run;
      end
      return best;
   endfunction

   // Frame-level reference: expected read/write streams and pixel class counts.
   task automatic build_model(input int mx, input int my, input int t);
      int c, p, v;
      logic [15:0] br, dk;
      exp_rd.delete();
      exp_wr.delete();
      n_int  = 0;
      n_bord = 0;
      for (int y = 0; y <= my; y++) begin
         for (int x = 0; x <= mx; x++) begin
            if (x < 3 || x > mx - 3 || y < 3 || y > my - 3) begin
               exp_wr.push_back(y * 2048 + x * 2);
               n_bord++;
            end else begin
               c = int'(img[y][x]);
               exp_rd.push_back(y * 1024 + x);
               for (int i = 0; i < 16; i++) begin
                  exp_rd.push_back((y + rdy[i]) * 1024 + x + rdx[i]);
                  p = int'(img[y + rdy[i]][x + rdx[i]]);
                  br[i] = (p > c + t);
                  dk[i] = (p + t < c);
               end
               v = (longest_run(br) >= 9 || longest_run(dk) >= 9) ? 1 : 0;
               exp_wr.push_back(y * 2048 + x * 2 + v);
               n_int++;
            end
         end
      end
   endtask

   task automatic fill_flat(input int v);
      for (int y = 0; y < 16; y++)
         for (int x = 0; x < 16; x++) img[y][x] = 8'(v);
   endtask

   task automatic set_ring(input int cx, input int cy, input logic [15:0] mask, input int v);
      for (int i = 0; i < 16; i++)
         if (mask[i]) img[cy + rdy[i]][cx + rdx[i]] = 8'(v);
   endtask

   task automatic start_frame(input int mx, input int my, input int t);
      rd_q.delete();
      wr_q.delete();
      overlap   = 0;
      done_busy = 0;
      bad_addr  = 0;
      first_act = -1;
      busy_c1   = -1;
      @(posedge clk); #1;
      max_x     = 9'(mx);
      max_y     = 9'(my);
      threshold = 8'(t);
      start     = 1'b1;
      start_cyc = cyc;
      @(posedge clk); #1;
      start     = 1'b0;
      // Scramble the parameter inputs; the DUT must keep its latched copies.
      max_x     = 9'($urandom_range(0, 3));
      max_y     = 9'($urandom_range(0, 3));
      threshold = 8'($urandom_range(0, 255));
   endtask

   task automatic run_frame(input string name, input int mx, input int my, input int t,
                            input bit poke);
      int budget, got, exp_cyc, n;
      build_model(mx, my, t);
      start_frame(mx, my, t);
      budget = 20 * (mx + 1) * (my + 1) + 20;
      got    = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk); #1;
         if (poke && i == 30) begin
            start = 1'b1; max_x = 9'd2; max_y = 9'd2; threshold = 8'd0;
         end
         if (poke && i == 31) start = 1'b0;
         if (done === 1'b1) begin
            got = 1;
            done_cyc = cyc - start_cyc;
            break;
         end
      end
      checks++;
      if (got == 0) begin
         errors++;
         $display("FAIL %s done_timeout: got no done, required done within %0d cycles", name, budget);
         return;
      end
      exp_cyc = 20 * n_int + n_bord + 1;
      checks++;
      if (done_cyc != exp_cyc) begin
         errors++;
         $display("FAIL %s done_cycle: got %0d required %0d", name, done_cyc, exp_cyc);
      end
      checks++;
      if (busy_c1 != 1) begin
         errors++;
         $display("FAIL %s busy_cycle1: got %0d required 1", name, busy_c1);
      end
      checks++;
      if (first_act != 1) begin
         errors++;
         $display("FAIL %s first_access_cycle: got %0d required 1", name, first_act);
      end
      checks++;
      if (overlap != 0 || done_busy != 0 || bad_addr != 0) begin
         errors++;
         $display("FAIL %s bus_rules: got overlap=%0d done_with_busy=%0d bad_addr=%0d required 0",
                  name, overlap, done_busy, bad_addr);
      end
      checks++;
      if (wr_q.size() != exp_wr.size()) begin
         errors++;
         $display("FAIL %s write_count: got %0d required %0d", name, wr_q.size(), exp_wr.size());
      end
      n = (wr_q.size() < exp_wr.size()) ? wr_q.size() : exp_wr.size();
      for (int i = 0; i < n; i++) begin
         checks++;
         if (wr_q[i] != exp_wr[i]) begin
            errors++;
            $display("FAIL %s write[%0d]: got (x=%0d,y=%0d,d=%0d) required (x=%0d,y=%0d,d=%0d)",
                     name, i, (wr_q[i] / 2) % 1024, wr_q[i] / 2048, wr_q[i] % 2,
                     (exp_wr[i] / 2) % 1024, exp_wr[i] / 2048, exp_wr[i] % 2);
         end
      end
      checks++;
      if (rd_q.size() != exp_rd.size()) begin
         errors++;
         $display("FAIL %s read_count: got %0d required %0d", name, rd_q.size(), exp_rd.size());
      end
      n = (rd_q.size() < exp_rd.size()) ? rd_q.size() : exp_rd.size();
      for (int i = 0; i < n; i++) begin
         checks++;
         if (rd_q[i] != exp_rd[i]) begin
            errors++;
            $display("FAIL %s read[%0d]: got (x=%0d,y=%0d) required (x=%0d,y=%0d)", name, i,
                     rd_q[i] % 1024, rd_q[i] / 1024, exp_rd[i] % 1024, exp_rd[i] / 1024);
         end
      end
   endtask

   // Spec-anchored check of one result bit independent of the model.
   task automatic check_pixel(input string name, input int px, input int py, input int exp_v);
      int found = -1;
      foreach (wr_q[i]) if (wr_q[i] / 2 == py * 1024 + px) found = wr_q[i] % 2;
      checks++;
      if (found != exp_v) begin
         errors++;
         $display("FAIL %s pixel(%0d,%0d): got %0d required %0d", name, px, py, found, exp_v);
      end
   endtask

   task automatic test_reset();
      n_rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      checks++;
      if ({xa_c, ya_c, ren, xa_f, ya_f, wen, wdat, busy, done} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got ren=%b wen=%b wdat=%b busy=%b done=%b xc=%0d yc=%0d xf=%0d yf=%0d required all 0",
                  ren, wen, wdat, busy, done, xa_c, ya_c, xa_f, ya_f);
      end
      n_rst = 1'b0;
   endtask

   task automatic test_flat();
      fill_flat(100);
      run_frame("flat7x7", 6, 6, 20, 1'b0);
      checks++;
      if (rd_q.size() != 17 || wr_q.size() != 49 || done_cyc != 69) begin
         errors++;
         $display("FAIL flat7x7_totals: got reads=%0d writes=%0d done=%0d required 17 49 69",
                  rd_q.size(), wr_q.size(), done_cyc);
      end
      check_pixel("flat7x7", 3, 3, 0);
   endtask

   task automatic test_arcs();
      fill_flat(100);
      set_ring(3, 3, 16'hFFFF, 150);
      run_frame("bright16", 6, 6, 20, 1'b0);
      check_pixel("bright16", 3, 3, 1);
      fill_flat(100);
      set_ring(3, 3, 16'h01FF, 50);
      run_frame("dark9", 6, 6, 20, 1'b0);
      check_pixel("dark9", 3, 3, 1);
      fill_flat(100);
      set_ring(3, 3, 16'h00FF, 50);
      run_frame("dark8", 6, 6, 20, 1'b0);
      check_pixel("dark8", 3, 3, 0);
      fill_flat(100);
      set_ring(3, 3, 16'hF01F, 200);
      run_frame("wrap9", 6, 6, 20, 1'b0);
      check_pixel("wrap9", 3, 3, 1);
   endtask

   task automatic test_saturation();
      fill_flat(255);
      img[3][3] = 8'd250;
      run_frame("sat_bright", 6, 6, 10, 1'b0);
      check_pixel("sat_bright", 3, 3, 0);
      fill_flat(0);
      img[3][3] = 8'd5;
      run_frame("sat_dark", 6, 6, 10, 1'b0);
      check_pixel("sat_dark", 3, 3, 0);
   endtask

   task automatic test_border_only();
      fill_flat(77);
      run_frame("border5x5", 4, 4, 5, 1'b0);
      checks++;
      if (rd_q.size() != 0 || wr_q.size() != 25) begin
         errors++;
         $display("FAIL border5x5_totals: got reads=%0d writes=%0d required 0 25",
                  rd_q.size(), wr_q.size());
      end
   endtask

   task automatic test_start_mid_scan();
      fill_flat(100);
      set_ring(3, 3, 16'hFFFF, 150);
      run_frame("mid_start", 6, 6, 20, 1'b1);
   endtask

   task automatic test_reset_mid_read();
      int got = 0;
      int nr, nw;
      fill_flat(100);
      start_frame(6, 6, 20);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk); #1;
         if (rd_q.size() == 9) begin
            got = 1;
            break;
         end
      end
      checks++;
      if (got == 0) begin
         errors++;
         $display("FAIL rst_mid_read_reach: got %0d reads required 9", rd_q.size());
         return;
      end
      n_rst = 1'b1;
      @(negedge clk); #1;
      checks++;
      if ({xa_c, ya_c, ren, xa_f, ya_f, wen, wdat, busy, done} !== '0) begin
         errors++;
         $display("FAIL rst_mid_read_outputs: got ren=%b wen=%b busy=%b done=%b xc=%0d yc=%0d required all 0",
                  ren, wen, busy, done, xa_c, ya_c);
      end
      n_rst = 1'b0;
      nr = rd_q.size();
      nw = wr_q.size();
      repeat (40) @(negedge clk);
      #1;
      checks++;
      if (rd_q.size() != nr || wr_q.size() != nw || busy !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_read_quiet: got reads=%0d writes=%0d busy=%b required %0d %0d 0",
                  rd_q.size(), wr_q.size(), busy, nr, nw);
      end
   endtask

   task automatic test_back_to_back();
      int got = 0;
      fill_flat(10);
      run_frame("b2b_first", 4, 4, 5, 1'b0);
      // Now inside the done cycle: a start here is ignored, held one more cycle it is accepted.
      wr_q.delete();
      max_x = 9'd4;
      max_y = 9'd4;
      start = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_start_on_done: got busy=%b required 0", busy);
      end
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL b2b_start_after_done: got busy=%b required 1", busy);
      end
      for (int i = 0; i < 100; i++) begin
         @(negedge clk); #1;
         if (done === 1'b1) begin
            got = 1;
            break;
         end
      end
      checks++;
      if (got == 0 || wr_q.size() != 25) begin
         errors++;
         $display("FAIL b2b_second_frame: got done=%0d writes=%0d required 1 25", got, wr_q.size());
      end
   endtask

   task automatic test_random();
      int mx, my, t, cx, cy, s, len;
      logic [15:0] mask;
      for (int f = 0; f < 6; f++) begin
         mx = $urandom_range(3, 11);
         my = $urandom_range(3, 11);
         t  = $urandom_range(0, 40);
         for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++) img[y][x] = 8'($urandom_range(90, 110));
         if (mx >= 6 && my >= 6) begin
            for (int a = 0; a < 3; a++) begin
               cx  = $urandom_range(3, mx - 3);
               cy  = $urandom_range(3, my - 3);
               s   = $urandom_range(0, 15);
               len = $urandom_range(6, 16);
               mask = '0;
               for (int j = 0; j < len; j++) mask[(s + j) % 16] = 1'b1;
               set_ring(cx, cy, mask, ($urandom_range(0, 1) == 1) ? 250 : 5);
            end
         end
         run_frame($sformatf("random%0d", f), mx, my, t, 1'b0);
      end
   endtask

   initial begin
      n_rst     = 1'b1;
      start     = 1'b0;
      max_x     = '0;
      max_y     = '0;
      threshold = '0;
      rdat      = '0;
      fill_flat(0);
      test_reset();
      test_flat();
      test_arcs();
      test_saturation();
      test_border_only();
      test_start_mid_scan();
      test_reset_mid_read();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fast_corner_scheduler.md
# fast_corner_scheduler

Sequences the FAST-9 corner test over the Gaussian-filtered image once convolution completes. It walks every pixel in raster order and fetches the centre pixel and the 16-pixel Bresenham ring from the conv buffer's fast read port. It then evaluates the contiguous-arc test and writes one result bit per pixel into the FAST output map. It sits between the GaussianConv write side (its `start` is driven by `conv_done`) and the FAST result memory.

## Interface
- `X_MAX`, 400, maximum image width
- `Y_MAX`, 400, maximum image height
- `PIXEL_DEPTH`, 8, bits per conv pixel
- `ARC_LEN`, 9, minimum contiguous ring length for a corner
- `clk`  in  1  system clock
- `n_rst`  in  1  reset: one clock; reset is synchronous and active-high (asserted = 1 clears state on the next `clk` rising edge)
- `start`  in  1  one-cycle pulse that begins a frame scan; ignored while `busy`
- `max_x`  in  $clog2(X_MAX)  last valid x index (width−1); sampled on accepted `start`
- `max_y`  in  $clog2(Y_MAX)  last valid y index (height−1); sampled on accepted `start`
- `threshold`  in  PIXEL_DEPTH  intensity threshold t; sampled on accepted `start`
- `x_addr_conv_fast`  out  $clog2(X_MAX)+1  conv read x address
- `y_addr_conv_fast`  out  $clog2(Y_MAX)+1  conv read y address
- `ren_conv_fast`  out  1  conv read enable
- `rdat_conv_fast`  in  PIXEL_DEPTH  conv read data, valid the cycle after `ren_conv_fast`
- `x_addr_fast`  out  $clog2(X_MAX)+1  result write x address
- `y_addr_fast`  out  $clog2(Y_MAX)+1  result write y address
- `wen_fast`  out  1  result write strobe
- `wdat_fast`  out  1  1 = corner
- `busy`  out  1  high from the cycle after accepted `start` until `done`
- `done`  out  1  one-cycle pulse after the last result write

## Operation
- States: IDLE → (SELECT → READ → CAPTURE → EVAL → WRITE)* → DONE → IDLE.
- IDLE: on `start`, latch `max_x`, `max_y` and `threshold`; set pixel (x,y)=(0,0); go to SELECT.
- SELECT is combinational with zero cycles, resolved in the same cycle as entry.
  - Border pixel: x<3, x>max_x−3, y<3 or y>max_y−3, compared in signed arithmetic so max<6 makes every pixel border. Go directly to WRITE with result 0 and issue no reads.
  - Interior pixel: go to READ.
- READ: 17 cycles with index k=0..16.
  - `ren_conv_fast`=1 each cycle.
  - k=0 reads the centre.
  - k=1..16 read ring offsets (dx,dy) in this order: (0,−3) (1,−3) (2,−2) (3,−1) (3,0) (3,1) (2,2) (1,3) (0,3) (−1,3) (−2,2) (−3,1) (−3,0) (−3,−1) (−2,−2) (−1,−3). +y is downward.
- Capture: data returned for index k is stored the following cycle. CAPTURE is the single cycle that stores index 16, with `ren_conv_fast`=0.
- EVAL, all in PIXEL_DEPTH+1-bit unsigned arithmetic with no wrap:
  - bright[i] = p_i > c+t.
  - dark[i] = p_i+t < c.
  - corner = 1 if bright or dark has ≥ARC_LEN contiguous set bits, treating bit 16 as adjacent to bit 1 (circular).
- WRITE: one cycle.
  - Drive `wen_fast`=1, addresses = (x,y), `wdat_fast` = result.
  - Advance x; at x=max_x, wrap x to 0 and increment y.
  - After (max_x,max_y), go to DONE; otherwise go to SELECT.
- DONE: pulse `done`=1 for one cycle, drop `busy`, return to IDLE.
- `start` in any non-IDLE state is ignored; the latched parameters are unchanged.
- Reset at any point, including mid-READ, returns to IDLE with no further reads or writes.

## Timing
- All outputs are registered. Reset value of every output is 0: addresses, `ren_conv_fast`, `wen_fast`, `wdat_fast`, `busy`, `done`.
- Accepted `start` at cycle 0:
  - `busy`=1 at cycle 1.
  - First `ren_conv_fast` or `wen_fast` at cycle 1.
- Interior pixel cost: 17 READ + 1 CAPTURE + 1 EVAL + 1 WRITE = 20 cycles.
- Border pixel cost: 1 cycle.
- `ren_conv_fast` and `wen_fast` are never high in the same cycle.
- `done` is asserted the cycle after the final WRITE. `busy` is low in that same cycle.
- Total frame cycles = 20·I + B + 1 (I interior count, B border count), counted from cycle 1 through `done`.
- A `start` arriving in the same cycle as `done` is ignored. A `start` one cycle later is accepted.

## Test plan
- 7×7 frame, `max_x`=`max_y`=6, flat value 100, t=20:
  - only (3,3) is read, with 17 reads;
  - 49 writes, all `wdat_fast`=0;
  - `done` at cycle 20+48+1=69.
- Same 7×7 frame with centre=100, all 16 ring pixels=150, t=20 → write at (3,3) with `wdat_fast`=1 (bright arc of 16).
- Centre=100; ring bits 1..9 at 50 and others at 100; t=20 → (3,3)=1 (dark arc of 9). With only bits 1..8 at 50 → (3,3)=0.
- Wrap-around arc: ring bits 13..16 and 1..5 at 200, others 100, centre 100, t=20 → (3,3)=1.
- Saturation check: centre=250, ring=255, t=10 → 0, with no wrap to a false bright. Centre=5, ring=0, t=10 → 0.
- Robustness:
  - 5×5 frame → 25 border writes, zero reads.
  - `n_rst` held for one cycle at READ index 8 → all outputs 0 next cycle; no writes until a new `start`.
  - `start` pulsed mid-scan → ignored.
